multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multi-cycle MIPS control unit: a Moore state machine that sequences fetch, decode, execute, memory and write-back over several clocks. It drives the shared-ALU, single-memory datapath from the latched instruction fields `OP`/`Function`. It adds a memory ready handshake, an optional access timeout, JAL/JR support and illegal-opcode detection. It sits between the instruction register and the datapath muxes, replacing the single-cycle decoder.

## Interface
- `MEM_TIMEOUT`, default 16: max wait cycles per memory access; 0 disables the timeout.
- `ENABLE_JAL_JR`, default 1: when 0, JAL and JR decode as illegal.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `OP` in 6: opcode from the instruction register.
- `Function` in 6: funct field from the instruction register.
- `mem_ready` in 1: memory completed the current read or write this cycle.
- `PCWrite` out 1: unconditional PC load.
- `PCWriteCondEQ` out 1: PC load if ALU zero.
- `PCWriteCondNE` out 1: PC load if not zero.
- `PCSource` out 2: 00 ALU result, 01 ALUOut, 10 jump target, 11 rs.
- `IorD` out 1: memory address select, 0 = PC, 1 = ALUOut.
- `MemRead` out 1: memory read request.
- `MemWrite` out 1: memory write request.
- `IRWrite` out 1: instruction register load.
- `RegDst` out 2: 00 rt, 01 rd, 10 $ra (31).
- `WriteDataSel` out 2: 00 ALUOut, 01 MDR, 10 PC.
- `RegWrite` out 1: register file write enable.
- `ALUSrcA` out 1: 0 = PC, 1 = rs.
- `ShamtSelector` out 1: ALU A input = shamt.
- `ALUSrcB` out 2: 00 rt, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2.
- `ALUOp` out 3: 100 add, 101 or, 110 lui, 111 R-type, 000 sub.
- `instr_done` out 1: one-cycle pulse on the last state of each instruction.
- `illegal_op` out 1: one-cycle pulse.
- `bus_error` out 1: one-cycle pulse on memory timeout.
- `state` out 4: current state, for debug.

## Operation
Decoded opcodes: R 0x00 (funct SLL 0x00, SRL 0x02, JR 0x08), J 0x02, JAL 0x03, BEQ 0x04, BNE 0x05, ADDI 0x08, ORI 0x0d, LUI 0x0f, LW 0x23, SW 0x2b.

Outputs not listed for a state are 0. The states are:
- **FETCH**: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=100, PCSource=00. IRWrite=PCWrite=mem_ready (combinational). Goes to DECODE when mem_ready=1.
- **DECODE**: ALUSrcA=0, ALUSrcB=11, ALUOp=100 (computes the branch target). Next state by opcode:
  - R (not JR) → EXEC_R; JR → JR.
  - ADDI, ORI, LUI → EXEC_I.
  - LW, SW → MEM_ADDR.
  - BEQ, BNE → BRANCH.
  - J → JUMP; JAL → JAL.
  - Anything else → ILLEGAL.
- **EXEC_R**: ALUSrcA=1, ALUSrcB=00, ALUOp=111. ShamtSelector=1 for SLL/SRL. → R_WB.
- **R_WB**: RegDst=01, WriteDataSel=00, RegWrite=1. → FETCH.
- **EXEC_I**: ALUSrcA=1, ALUSrcB=10. ALUOp is 100 for ADDI, 101 for ORI, 110 for LUI. → I_WB.
- **I_WB**: RegDst=00, WriteDataSel=00, RegWrite=1. → FETCH.
- **MEM_ADDR**: ALUSrcA=1, ALUSrcB=10, ALUOp=100. → MEM_READ for LW, MEM_WRITE for SW.
- **MEM_READ**: MemRead=1, IorD=1. Holds until mem_ready, then → MEM_WB.
- **MEM_WB**: RegDst=00, WriteDataSel=01, RegWrite=1. → FETCH.
- **MEM_WRITE**: MemWrite=1, IorD=1. Holds until mem_ready, then → FETCH.
- **BRANCH**: ALUSrcA=1, ALUSrcB=00, ALUOp=000, PCSource=01. PCWriteCondEQ=1 for BEQ, PCWriteCondNE=1 for BNE. → FETCH.
- **JUMP**: PCWrite=1, PCSource=10. → FETCH.
- **JAL**: PCWrite=1, PCSource=10, RegWrite=1, RegDst=10, WriteDataSel=10. The PC already holds PC+4 in this state. → FETCH.
- **JR**: PCWrite=1, PCSource=11. → FETCH.
- **ILLEGAL**: illegal_op=1, no writes. → FETCH.

instr_done=1 in every state whose next state is FETCH, except ILLEGAL and timeout exits.

## Timing
- Reset:
  - While `reset`=1, all control outputs are forced to 0.
  - On the clock edge, state ← FETCH and the wait counter ← 0.
  - The first cycle after reset is FETCH with MemRead=1.
  - Reset mid-access drops the request; no writes occur.
- Cycle counts with mem_ready tied high:
  - R-type, I-type, SW: 4 cycles.
  - LW: 5 cycles.
  - BEQ, BNE, J, JAL, JR: 3 cycles.
  - Each memory wait adds 1 cycle.
- Wait counter:
  - Clears on entry to FETCH, MEM_READ or MEM_WRITE.
  - Increments each cycle the state waits with mem_ready=0.
  - Saturates at MEM_TIMEOUT.
- Timeout (MEM_TIMEOUT>0): when the counter equals MEM_TIMEOUT and mem_ready=0:
  - bus_error pulses for one cycle.
  - State → FETCH with no IRWrite, PCWrite or RegWrite.
  - A FETCH timeout re-fetches the same PC.
- mem_ready arriving in the same cycle as the timeout wins: the access completes normally and bus_error stays 0.
- mem_ready outside the memory states is ignored.

## Test plan
- **Reset:** hold reset 2 cycles → all outputs 0, then state=FETCH with MemRead=1.
- **ADD:** OP=0x00, Funct=0x20, mem_ready=1 → RegWrite=1 with RegDst=01 in the 4th cycle; instr_done pulses once.
- **LW with stalls:** OP=0x23, mem_ready low 3 cycles in MEM_READ → MemRead held 4 cycles, total 8 cycles, WriteDataSel=01.
- **BNE and JAL:** BNE → PCWriteCondNE=1 in cycle 3. JAL → RegDst=10, WriteDataSel=10, PCWrite=1 in cycle 3.
- **Illegal opcode:** OP=0x3f → illegal_op pulses in cycle 3, no write strobes, back to FETCH. With ENABLE_JAL_JR=0, JR behaves the same way.
- **Timeout:** MEM_TIMEOUT=4, mem_ready=0 in FETCH → bus_error pulses after 4 wait cycles, re-fetch occurs, IRWrite never asserts.

Source files
------------

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control unit: Moore FSM sequencing fetch/decode/execute/memory/write-back,
// with a memory ready handshake, optional access timeout, JAL/JR and illegal-opcode detection.
module multicycle_control #(
   parameter int unsigned MEM_TIMEOUT   = 16,
   parameter int unsigned ENABLE_JAL_JR = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] OP,
   input  logic [5:0] Function,
   input  logic       mem_ready,
   output logic       PCWrite,
   output logic       PCWriteCondEQ,
   output logic       PCWriteCondNE,
   output logic [1:0] PCSource,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic [1:0] RegDst,
   output logic [1:0] WriteDataSel,
   output logic       RegWrite,
   output logic       ALUSrcA,
   output logic       ShamtSelector,
   output logic [1:0] ALUSrcB,
   output logic [2:0] ALUOp,
   output logic       instr_done,
   output logic       illegal_op,
   output logic       bus_error,
   output logic [3:0] state
);

   localparam logic [5:0] OpR    = 6'h00;
   localparam logic [5:0] OpJ    = 6'h02;
   localparam logic [5:0] OpJal  = 6'h03;
   localparam logic [5:0] OpBeq  = 6'h04;
   localparam logic [5:0] OpBne  = 6'h05;
   localparam logic [5:0] OpAddi = 6'h08;
   localparam logic [5:0] OpOri  = 6'h0d;
   localparam logic [5:0] OpLui  = 6'h0f;
   localparam logic [5:0] OpLw   = 6'h23;
   localparam logic [5:0] OpSw   = 6'h2b;

   localparam logic [5:0] FnSll = 6'h00;
   localparam logic [5:0] FnSrl = 6'h02;
   localparam logic [5:0] FnJr  = 6'h08;

   localparam int unsigned CntW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
   localparam logic [CntW-1:0] TimeoutVal = CntW'(MEM_TIMEOUT);

   typedef enum logic [3:0] {
      StFetch    = 4'd0,
      StDecode   = 4'd1,
      StExecR    = 4'd2,
      StRWb      = 4'd3,
      StExecI    = 4'd4,
      StIWb      = 4'd5,
      StMemAddr  = 4'd6,
      StMemRead  = 4'd7,
      StMemWb    = 4'd8,
      StMemWrite = 4'd9,
      StBranch   = 4'd10,
      StJump     = 4'd11,
      StJal      = 4'd12,
      StJr       = 4'd13,
      StIllegal  = 4'd14
   } state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            waiting, timeout, jal_jr_en;

   assign jal_jr_en = (ENABLE_JAL_JR != 0);
   assign waiting   = (state_q == StFetch) || (state_q == StMemRead) || (state_q == StMemWrite);
   // A ready arriving on the timeout cycle completes the access instead.
   assign timeout   = (MEM_TIMEOUT != 0) && waiting && !mem_ready && (cnt_q == TimeoutVal);
   assign state     = state_q;

   always_comb begin
      state_d       = state_q;
      PCWrite       = 1'b0;
      PCWriteCondEQ = 1'b0;
      PCWriteCondNE = 1'b0;
      PCSource      = 2'b00;
      IorD          = 1'b0;
      MemRead       = 1'b0;
      MemWrite      = 1'b0;
      IRWrite       = 1'b0;
      RegDst        = 2'b00;
      WriteDataSel  = 2'b00;
      RegWrite      = 1'b0;
      ALUSrcA       = 1'b0;
      ShamtSelector = 1'b0;
      ALUSrcB       = 2'b00;
      ALUOp         = 3'b000;
      instr_done    = 1'b0;
      illegal_op    = 1'b0;
      bus_error     = 1'b0;

      case (state_q)
         StFetch: begin
            MemRead = 1'b1;
            ALUSrcB = 2'b01;
            ALUOp   = 3'b100;
            IRWrite = mem_ready;
            PCWrite = mem_ready;
            if (mem_ready) begin
               state_d = StDecode;
            end else if (timeout) begin
               bus_error = 1'b1;
               state_d   = StFetch;
            end
         end
         StDecode: begin
            ALUSrcB = 2'b11;
            ALUOp   = 3'b100;
            case (OP)
               OpR: begin
                  if (Function != FnJr) state_d = StExecR;
                  else if (jal_jr_en)   state_d = StJr;
                  else                  state_d = StIllegal;
               end
               OpJ:                   state_d = StJump;
               OpJal:                 state_d = jal_jr_en ? StJal : StIllegal;
               OpBeq, OpBne:          state_d = StBranch;
               OpAddi, OpOri, OpLui:  state_d = StExecI;
               OpLw, OpSw:            state_d = StMemAddr;
               default:               state_d = StIllegal;
            endcase
         end
         StExecR: begin
            ALUSrcA       = 1'b1;
            ALUOp         = 3'b111;
            ShamtSelector = (Function == FnSll) || (Function == FnSrl);
            state_d       = StRWb;
         end
         StRWb: begin
            RegDst     = 2'b01;
            RegWrite   = 1'b1;
            instr_done = 1'b1;
            state_d    = StFetch;
         end
         StExecI: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            case (OP)
               OpOri:   ALUOp = 3'b101;
               OpLui:   ALUOp = 3'b110;
               default: ALUOp = 3'b100;
            endcase
            state_d = StIWb;
         end
         StIWb: begin
            RegWrite   = 1'b1;
            instr_done = 1'b1;
            state_d    = StFetch;
         end
         StMemAddr: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            ALUOp   = 3'b100;
            state_d = (OP == OpSw) ? StMemWrite : StMemRead;
         end
         StMemRead: begin
            MemRead = 1'b1;
            IorD    = 1'b1;
            if (mem_ready) begin
               state_d = StMemWb;
            end else if (timeout) begin
               bus_error = 1'b1;
               state_d   = StFetch;
            end
         end
         StMemWb: begin
            WriteDataSel = 2'b01;
            RegWrite     = 1'b1;
            instr_done   = 1'b1;
            state_d      = StFetch;
         end
         StMemWrite: begin
            MemWrite = 1'b1;
            IorD     = 1'b1;
            if (mem_ready) begin
               instr_done = 1'b1;
               state_d    = StFetch;
            end else if (timeout) begin
               bus_error = 1'b1;
               state_d   = StFetch;
            end
         end
         StBranch: begin
            ALUSrcA       = 1'b1;
            PCSource      = 2'b01;
            PCWriteCondEQ = (OP == OpBeq);
            PCWriteCondNE = (OP == OpBne);
            instr_done    = 1'b1;
            state_d       = StFetch;
         end
         StJump: begin
            PCWrite    = 1'b1;
            PCSource   = 2'b10;
            instr_done = 1'b1;
            state_d    = StFetch;
         end
         StJal: begin
            PCWrite      = 1'b1;
            PCSource     = 2'b10;
            RegWrite     = 1'b1;
            RegDst       = 2'b10;
            WriteDataSel = 2'b10;
            instr_done   = 1'b1;
            state_d      = StFetch;
         end
         StJr: begin
            PCWrite    = 1'b1;
            PCSource   = 2'b11;
            instr_done = 1'b1;
            state_d    = StFetch;
         end
         StIllegal: begin
            illegal_op = 1'b1;
            state_d    = StFetch;
         end
         default: state_d = StFetch;
      endcase

      // Reset drops any in-flight request and suppresses every strobe.
      if (reset) begin
         PCWrite       = 1'b0;
         PCWriteCondEQ = 1'b0;
         PCWriteCondNE = 1'b0;
         PCSource      = 2'b00;
         IorD          = 1'b0;
         MemRead       = 1'b0;
         MemWrite      = 1'b0;
         IRWrite       = 1'b0;
         RegDst        = 2'b00;
         WriteDataSel  = 2'b00;
         RegWrite      = 1'b0;
         ALUSrcA       = 1'b0;
         ShamtSelector = 1'b0;
         ALUSrcB       = 2'b00;
         ALUOp         = 3'b000;
         instr_done    = 1'b0;
         illegal_op    = 1'b0;
         bus_error     = 1'b0;
      end
   end

   // Any state change (including a timeout re-entry to FETCH) restarts the wait count.
   always_comb begin
      cnt_d = cnt_q;
      if (timeout || (state_d != state_q)) begin
         cnt_d = '0;
      end else if (waiting && !mem_ready && (cnt_q != TimeoutVal)) begin
         cnt_d = cnt_q + CntW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StFetch;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: an instruction-level model expands each instruction into its
// expected per-cycle control vector; two DUTs (JAL/JR on and off) run in lockstep.
module tb_multicycle_control;

   localparam int unsigned TO = 4;

   typedef struct packed {
      logic       pcw;
      logic       pceq;
      logic       pcne;
      logic [1:0] pcsrc;
      logic       iord;
      logic       mrd;
      logic       mwr;
      logic       irw;
      logic [1:0] regdst;
      logic [1:0] wds;
      logic       regw;
      logic       srca;
      logic       shamt;
      logic [1:0] srcb;
      logic [2:0] aluop;
      logic       done;
      logic       ill;
      logic       berr;
   } ctl_t;

   typedef struct {
      logic       rst;
      logic       rdy;
      logic [5:0] op;
      logic [5:0] fn;
      ctl_t       e1;
      ctl_t       e2;
   } step_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       mem_ready = 1'b0;
   logic [5:0] op = '0, funct = '0;

   logic       pcw1, pceq1, pcne1, iord1, mrd1, mwr1, irw1, regw1, srca1, shamt1;
   logic       done1, ill1, berr1;
   logic [1:0] pcsrc1, regdst1, wds1, srcb1;
   logic [2:0] aluop1;
   logic [3:0] state1;
   logic       pcw2, pceq2, pcne2, iord2, mrd2, mwr2, irw2, regw2, srca2, shamt2;
   logic       done2, ill2, berr2;
   logic [1:0] pcsrc2, regdst2, wds2, srcb2;
   logic [2:0] aluop2;
   logic [3:0] state2;

   ctl_t a1, a2, x1, x2;
   assign a1 = {pcw1, pceq1, pcne1, pcsrc1, iord1, mrd1, mwr1, irw1, regdst1, wds1, regw1,
                srca1, shamt1, srcb1, aluop1, done1, ill1, berr1};
   assign a2 = {pcw2, pceq2, pcne2, pcsrc2, iord2, mrd2, mwr2, irw2, regdst2, wds2, regw2,
                srca2, shamt2, srcb2, aluop2, done2, ill2, berr2};

   multicycle_control #(.MEM_TIMEOUT(TO), .ENABLE_JAL_JR(1)) dut (
      .clk(clk), .reset(reset), .OP(op), .Function(funct), .mem_ready(mem_ready),
      .PCWrite(pcw1), .PCWriteCondEQ(pceq1), .PCWriteCondNE(pcne1), .PCSource(pcsrc1),
      .IorD(iord1), .MemRead(mrd1), .MemWrite(mwr1), .IRWrite(irw1), .RegDst(regdst1),
      .WriteDataSel(wds1), .RegWrite(regw1), .ALUSrcA(srca1), .ShamtSelector(shamt1),
      .ALUSrcB(srcb1), .ALUOp(aluop1), .instr_done(done1), .illegal_op(ill1),
      .bus_error(berr1), .state(state1)
   );

   multicycle_control #(.MEM_TIMEOUT(TO), .ENABLE_JAL_JR(0)) dut_nojal (
      .clk(clk), .reset(reset), .OP(op), .Function(funct), .mem_ready(mem_ready),
      .PCWrite(pcw2), .PCWriteCondEQ(pceq2), .PCWriteCondNE(pcne2), .PCSource(pcsrc2),
      .IorD(iord2), .MemRead(mrd2), .MemWrite(mwr2), .IRWrite(irw2), .RegDst(regdst2),
      .WriteDataSel(wds2), .RegWrite(regw2), .ALUSrcA(srca2), .ShamtSelector(shamt2),
      .ALUSrcB(srcb2), .ALUOp(aluop2), .instr_done(done2), .illegal_op(ill2),
      .bus_error(berr2), .state(state2)
   );

   always #5 clk = ~clk;

   step_t      q[$];
   ctl_t       hist[$];
   ctl_t       hist2[$];
   logic [3:0] hist_st[$];
   logic       chk_en = 1'b0;
   logic       tog = 1'b0;
   logic [5:0] cur_op = '0, cur_fn = '0;
   int         errors = 0;
   int         checks = 0;

   task automatic cmp(input string name, input ctl_t got, input ctl_t want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h required %h at %0t", name, got, want, $time);
      end
   endtask

   task automatic lit(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s: got %0d required %0d", name, got, want);
      end
   endtask

   // Sample between edges once both inputs and combinational outputs have settled.
   always @(negedge clk) begin
      if (chk_en) begin
         cmp("ctl", a1, x1);
         cmp("ctl_nojal", a2, x2);
         if (x1 == x2) begin
            checks++;
            if (state1 !== state2) begin
               errors++;
               $display("FAIL state_lockstep: got %0d required %0d", state2, state1);
            end
         end
         hist.push_back(a1);
         hist2.push_back(a2);
         hist_st.push_back(state1);
      end
   end

   task automatic push(input logic rst, input logic rdy, input ctl_t e1, input ctl_t e2);
      step_t s;
      s.rst = rst; s.rdy = rdy; s.op = cur_op; s.fn = cur_fn; s.e1 = e1; s.e2 = e2;
      q.push_back(s);
   endtask

   // Non-memory cycles get a toggling mem_ready, which must have no effect.
   task automatic push_any(input ctl_t e1, input ctl_t e2);
      push(1'b0, tog, e1, e2);
      tog = ~tog;
   endtask

   function automatic ctl_t c_fetch(input logic rdy, input logic berr);
      ctl_t c = '0;
      c.mrd = 1'b1; c.srcb = 2'b01; c.aluop = 3'b100;
      c.irw = rdy; c.pcw = rdy; c.berr = berr;
      return c;
   endfunction

   // fw > TO models a fetch timeout followed by a clean re-fetch.
   task automatic fetch(input int fw);
      int w = fw;
      if (w > TO) begin
         repeat (TO) push(1'b0, 1'b0, c_fetch(1'b0, 1'b0), c_fetch(1'b0, 1'b0));
         push(1'b0, 1'b0, c_fetch(1'b0, 1'b1), c_fetch(1'b0, 1'b1));
         w = 0;
      end
      repeat (w) push(1'b0, 1'b0, c_fetch(1'b0, 1'b0), c_fetch(1'b0, 1'b0));
      push(1'b0, 1'b1, c_fetch(1'b1, 1'b0), c_fetch(1'b1, 1'b0));
   endtask

   task automatic instr(input logic [5:0] o, input logic [5:0] f, input int fw, input int mw);
      ctl_t c, c2, w;
      cur_op = o; cur_fn = f;
      fetch(fw);
      c = '0; c.srcb = 2'b11; c.aluop = 3'b100;
      push_any(c, c);
      c = '0; c2 = '0; c2.ill = 1'b1;
      case (o)
         6'h00: begin
            if (f == 6'h08) begin
               c.pcw = 1'b1; c.pcsrc = 2'b11; c.done = 1'b1;
               push_any(c, c2);
            end else begin
               c.srca = 1'b1; c.aluop = 3'b111; c.shamt = (f == 6'h00) || (f == 6'h02);
               push_any(c, c);
               c = '0; c.regdst = 2'b01; c.regw = 1'b1; c.done = 1'b1;
               push_any(c, c);
            end
         end
         6'h08, 6'h0d, 6'h0f: begin
            c.srca = 1'b1; c.srcb = 2'b10;
            c.aluop = (o == 6'h08) ? 3'b100 : (o == 6'h0d) ? 3'b101 : 3'b110;
            push_any(c, c);
            c = '0; c.regw = 1'b1; c.done = 1'b1;
            push_any(c, c);
         end
         6'h23, 6'h2b: begin
            c.srca = 1'b1; c.srcb = 2'b10; c.aluop = 3'b100;
            push_any(c, c);
            w = '0; w.iord = 1'b1; w.mrd = (o == 6'h23); w.mwr = (o == 6'h2b);
            if (mw > TO) begin
               repeat (TO) push(1'b0, 1'b0, w, w);
               w.berr = 1'b1;
               push(1'b0, 1'b0, w, w);
            end else begin
               repeat (mw) push(1'b0, 1'b0, w, w);
               w.done = (o == 6'h2b);
               push(1'b0, 1'b1, w, w);
               if (o == 6'h23) begin
                  c = '0; c.wds = 2'b01; c.regw = 1'b1; c.done = 1'b1;
                  push_any(c, c);
               end
            end
         end
         6'h04, 6'h05: begin
            c.srca = 1'b1; c.pcsrc = 2'b01; c.done = 1'b1;
            c.pceq = (o == 6'h04); c.pcne = (o == 6'h05);
            push_any(c, c);
         end
         6'h02: begin
            c.pcw = 1'b1; c.pcsrc = 2'b10; c.done = 1'b1;
            push_any(c, c);
         end
         6'h03: begin
            c.pcw = 1'b1; c.pcsrc = 2'b10; c.regw = 1'b1; c.regdst = 2'b10; c.wds = 2'b10;
            c.done = 1'b1;
            push_any(c, c2);
         end
         default: push_any(c2, c2);
      endcase
   endtask

   task automatic play();
      step_t s;
      while (q.size() > 0) begin
         s = q.pop_front();
         reset = s.rst; mem_ready = s.rdy; op = s.op; funct = s.fn;
         x1 = s.e1; x2 = s.e2;
         chk_en = 1'b1;
         @(posedge clk);
         #1;
      end
      chk_en = 1'b0;
   endtask

   initial begin
      int b, n;
      ctl_t w;
      @(posedge clk);
      #1;
      push(1'b1, 1'b1, '0, '0);
      push(1'b1, 1'b0, '0, '0);
      play();
      lit("reset_outputs_zero", int'(hist[1]), 0);

      b = hist.size();
      instr(6'h00, 6'h20, 0, 0);
      instr(6'h00, 6'h00, 0, 0);
      play();
      lit("first_fetch_memread", hist[b].mrd, 1);
      lit("add_regwrite_c4", hist[b+3].regw, 1);
      lit("add_regdst_c4", hist[b+3].regdst, 1);
      n = 0;
      for (int i = b; i < b + 4; i++) n += hist[i].done;
      lit("add_done_pulses", n, 1);
      lit("add_back_to_fetch", hist_st[b+4], hist_st[b]);
      lit("add_state_moves", int'(hist_st[b+2] != hist_st[b+1]), 1);

      instr(6'h00, 6'h02, 1, 0);
      instr(6'h08, 6'h00, 0, 0);
      instr(6'h0d, 6'h00, 2, 0);
      instr(6'h0f, 6'h00, 0, 0);
      play();

      b = hist.size();
      instr(6'h23, 6'h00, 0, 3);
      play();
      n = 0;
      for (int i = b + 3; i < b + 7; i++) n += hist[i].mrd;
      lit("lw_memread_held", n, 4);
      lit("lw_total_cycles", hist.size() - b, 8);
      lit("lw_wds_mdr", hist[b+7].wds, 1);

      instr(6'h2b, 6'h00, 0, 0);
      instr(6'h2b, 6'h00, 0, 2);
      instr(6'h04, 6'h00, 0, 0);
      play();

      b = hist.size();
      instr(6'h05, 6'h00, 0, 0);
      instr(6'h03, 6'h00, 0, 0);
      play();
      lit("bne_condne_c3", hist[b+2].pcne, 1);
      lit("jal_regdst_c3", hist[b+5].regdst, 2);
      lit("jal_wds_c3", hist[b+5].wds, 2);
      lit("jal_pcwrite_c3", hist[b+5].pcw, 1);
      lit("nojal_jal_illegal", hist2[b+5].ill, 1);

      b = hist.size();
      instr(6'h3f, 6'h00, 0, 0);
      instr(6'h00, 6'h08, 0, 0);
      instr(6'h02, 6'h00, 0, 0);
      play();
      lit("illegal_pulse_c3", hist[b+2].ill, 1);
      w = hist[b+2];
      lit("illegal_no_writes", int'({w.pcw, w.regw, w.mwr, w.irw, w.done}), 0);
      lit("nojal_jr_illegal", hist2[b+5].ill, 1);

      // Ready on the timeout cycle completes normally.
      instr(6'h00, 6'h20, TO, 0);
      instr(6'h23, 6'h00, 0, TO);
      play();

      b = hist.size();
      instr(6'h00, 6'h20, 99, 0);
      play();
      n = 0;
      for (int i = b; i < b + 5; i++) n += hist[i].irw;
      lit("timeout_no_irwrite", n, 0);
      lit("timeout_bus_error", hist[b+4].berr, 1);
      lit("refetch_irwrite", hist[b+5].irw, 1);

      instr(6'h23, 6'h00, 0, 99);
      instr(6'h2b, 6'h00, 0, 99);
      play();

      // Reset while a store waits: outputs drop, then a clean fetch follows.
      cur_op = 6'h2b; cur_fn = 6'h00;
      fetch(0);
      w = '0; w.srcb = 2'b11; w.aluop = 3'b100;
      push_any(w, w);
      w = '0; w.srca = 1'b1; w.srcb = 2'b10; w.aluop = 3'b100;
      push_any(w, w);
      w = '0; w.iord = 1'b1; w.mwr = 1'b1;
      push(1'b0, 1'b0, w, w);
      push(1'b1, 1'b1, '0, '0);
      instr(6'h08, 6'h00, 0, 0);
      play();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
